// File: rtl/axil_client_req_bridge.sv
// axil_client_req_bridge: AXI4-Lite slave to single-outstanding req/gnt register-bus bridge.
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   s_axil_aw*/w*/b*           AXI-Lite write address/data/response channels (awprot ignored)
//   s_axil_ar*/r*              AXI-Lite read address/data channels (arprot ignored)
//   req_o/gnt_i                device request handshake, addr_o/we_o/wdata_o/be_o/size_o held while req_o
//   valid_i/rdata_i            device response, captured into a one-entry response buffer
module axil_client_req_bridge #(
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 32,
  parameter int dev_addr_width_p  = 22
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
  input  logic [2:0]                     s_axil_awprot_i,
  input  logic                           s_axil_awvalid_i,
  output logic                           s_axil_awready_o,
  input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
  input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
  input  logic                           s_axil_wvalid_i,
  output logic                           s_axil_wready_o,
  output logic [1:0]                     s_axil_bresp_o,
  output logic                           s_axil_bvalid_o,
  input  logic                           s_axil_bready_i,
  input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
  input  logic [2:0]                     s_axil_arprot_i,
  input  logic                           s_axil_arvalid_i,
  output logic                           s_axil_arready_o,
  output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
  output logic [1:0]                     s_axil_rresp_o,
  output logic                           s_axil_rvalid_o,
  input  logic                           s_axil_rready_i,
  output logic                           req_o,
  input  logic                           gnt_i,
  output logic [dev_addr_width_p-1:0]    addr_o,
  output logic                           we_o,
  output logic [axil_data_width_p-1:0]   wdata_o,
  output logic [axil_data_width_p/8-1:0] be_o,
  output logic [1:0]                     size_o,
  input  logic                           valid_i,
  input  logic [axil_data_width_p-1:0]   rdata_i
);
  localparam int SB = axil_data_width_p / 8;
  localparam int LG = $clog2(SB);
  logic                         cmd_v_q, cmd_v_d, cmd_we_q, cmd_we_d, busy_q, busy_d, resp_v_q, resp_v_d;
  logic [dev_addr_width_p-1:0]  cmd_addr_q, cmd_addr_d;
  logic [axil_data_width_p-1:0] cmd_wdata_q, cmd_wdata_d, resp_data_q, resp_data_d;
  logic [1:0]                   cmd_size_q, cmd_size_d, size_w;
  logic [SB-1:0]                mask;
  logic                         wr_pair, aw_hs, ar_hs, pop, resp_ld, unused;
  assign unused = ^{s_axil_awaddr_i, s_axil_araddr_i, s_axil_awprot_i, s_axil_arprot_i};
  assign wr_pair = s_axil_awvalid_i & s_axil_wvalid_i;
  assign s_axil_awready_o = rst_ni & ~cmd_v_q & wr_pair;
  assign s_axil_wready_o  = s_axil_awready_o;
  assign s_axil_arready_o = rst_ni & ~cmd_v_q & s_axil_arvalid_i & ~wr_pair;
  assign aw_hs = s_axil_awready_o;
  assign ar_hs = s_axil_arready_o;
  assign req_o = cmd_v_q & ~busy_q;
  assign addr_o = cmd_addr_q;
  assign we_o = cmd_we_q;
  assign wdata_o = cmd_wdata_q;
  assign size_o = cmd_size_q;
  assign be_o = '1;
  assign s_axil_bvalid_o = resp_v_q & cmd_we_q;
  assign s_axil_rvalid_o = resp_v_q & ~cmd_we_q;
  assign s_axil_rdata_o = resp_data_q;
  assign s_axil_bresp_o = 2'b00;
  assign s_axil_rresp_o = 2'b00;
  assign pop = (s_axil_bvalid_o & s_axil_bready_i) | (s_axil_rvalid_o & s_axil_rready_i);
  // Responses only count while a device transaction is outstanding, so stray
  // valid_i after a reset cannot fabricate a B/R beat.
  assign resp_ld = valid_i & ~resp_v_q & busy_q;
  // Contiguous low-lane strobes map to their byte-count log2; anything else is a full word.
  always_comb begin
    size_w = 2'(LG);
    mask = '0;
    for (int i = 0; i <= LG; i++) begin
      mask = SB'((1 << (1 << i)) - 1);
      size_w = (s_axil_wstrb_i == mask) ? 2'(i) : size_w;
    end
  end
  always_comb begin
    cmd_v_d = pop ? 1'b0 : (aw_hs | ar_hs) ? 1'b1 : cmd_v_q;
    cmd_we_d = aw_hs ? 1'b1 : ar_hs ? 1'b0 : cmd_we_q;
    cmd_addr_d = aw_hs ? s_axil_awaddr_i[dev_addr_width_p-1:0] : ar_hs ? s_axil_araddr_i[dev_addr_width_p-1:0] : cmd_addr_q;
    cmd_wdata_d = aw_hs ? s_axil_wdata_i : ar_hs ? '0 : cmd_wdata_q;
    cmd_size_d = aw_hs ? size_w : ar_hs ? 2'(LG) : cmd_size_q;
    busy_d = (req_o & gnt_i) ? 1'b1 : pop ? 1'b0 : busy_q;
    resp_v_d = pop ? 1'b0 : resp_ld ? 1'b1 : resp_v_q;
    resp_data_d = resp_ld ? rdata_i : resp_data_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_v_q <= 1'b0;
      cmd_we_q <= 1'b0;
      cmd_addr_q <= '0;
      cmd_wdata_q <= '0;
      cmd_size_q <= '0;
      busy_q <= 1'b0;
      resp_v_q <= 1'b0;
      resp_data_q <= '0;
    end else begin
      cmd_v_q <= cmd_v_d;
      cmd_we_q <= cmd_we_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_size_q <= cmd_size_d;
      busy_q <= busy_d;
      resp_v_q <= resp_v_d;
      resp_data_q <= resp_data_d;
    end
  end
endmodule

// File: tb/tb_axil_client_req_bridge.sv
// tb_axil_client_req_bridge: directed self-checking bench for axil_client_req_bridge.
module tb_axil_client_req_bridge;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata_o, wdata_o, rdata_i = '0;
  logic [3:0]  wstrb = '0, be;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic        awready, wready, arready, bvalid, rvalid, req, we, gnt = 1'b0, dvalid = 1'b0;
  logic [1:0]  bresp, rresp, size;
  logic [21:0] addr;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  axil_client_req_bridge dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(3'b000), .s_axil_awvalid_i(awvalid), .s_axil_awready_o(awready),
    .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid), .s_axil_wready_o(wready),
    .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
    .s_axil_araddr_i(araddr), .s_axil_arprot_i(3'b000), .s_axil_arvalid_i(arvalid), .s_axil_arready_o(arready),
    .s_axil_rdata_o(rdata_o), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid), .s_axil_rready_i(rready),
    .req_o(req), .gnt_i(gnt), .addr_o(addr), .we_o(we), .wdata_o(wdata_o), .be_o(be), .size_o(size),
    .valid_i(dvalid), .rdata_i(rdata_i)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    tick();
    tick();
    chk("rst_req", 32'(req), 0);
    chk("rst_readies", {awready, wready, arready}, 0);
    chk("rst_valids", {bvalid, rvalid}, 0);
    chk("rst_data", {addr, we, size}, 0);
    rst_n = 1'b1;
    tick();
    // write with immediate grant, response one cycle later
    awaddr = 32'h0030_B004; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1; gnt = 1;
    #1;
    chk("w1_aw_w_ready", {awready, wready, arready}, 3'b110);
    chk("w1_req_c0", 32'(req), 0);
    tick();
    awvalid = 0; wvalid = 0;
    chk("w1_req", 32'(req), 1);
    chk("w1_we", 32'(we), 1);
    chk("w1_addr", 32'(addr), 32'h30_B004);
    chk("w1_be", 32'(be), 4'hF);
    chk("w1_size", 32'(size), 2);
    chk("w1_wdata", wdata_o, 32'hDEAD_BEEF);
    tick();
    gnt = 0; dvalid = 1;
    chk("w1_req_after_gnt", 32'(req), 0);
    chk("w1_bvalid_early", 32'(bvalid), 0);
    tick();
    dvalid = 0; bready = 1;
    chk("w1_bvalid", 32'(bvalid), 1);
    chk("w1_bresp", 32'(bresp), 0);
    chk("w1_rvalid", 32'(rvalid), 0);
    tick();
    bready = 0;
    chk("w1_popped", 32'(bvalid), 0);
    // read with grant delayed three cycles
    araddr = 32'hFFC0_0010; arvalid = 1;
    #1;
    chk("r1_arready", 32'(arready), 1);
    tick();
    arvalid = 0;
    chk("r1_addr", 32'(addr), 32'h10);
    chk("r1_we", 32'(we), 0);
    chk("r1_size", 32'(size), 2);
    chk("r1_wdata", wdata_o, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("r1_req_held%0d", i), 32'(req), 1);
      if (i == 3) gnt = 1;
      tick();
    end
    gnt = 0; dvalid = 1; rdata_i = 32'h1234_5678;
    chk("r1_req_dropped", 32'(req), 0);
    chk("r1_rvalid_early", 32'(rvalid), 0);
    tick();
    dvalid = 0; rdata_i = 0;
    chk("r1_rvalid", 32'(rvalid), 1);
    chk("r1_rdata", rdata_o, 32'h1234_5678);
    chk("r1_rresp", 32'(rresp), 0);
    chk("r1_bvalid", 32'(bvalid), 0);
    tick();
    chk("r1_held", 32'(rvalid), 1);
    rready = 1;
    tick();
    rready = 0;
    chk("r1_popped", 32'(rvalid), 0);
    // AW, W and AR together: write wins, read follows the B handshake
    awaddr = 32'h100; wdata = 32'h11; wstrb = 4'h1; awvalid = 1; wvalid = 1; araddr = 32'h200; arvalid = 1;
    #1;
    chk("pri_readies", {awready, wready, arready}, 3'b110);
    tick();
    awvalid = 0; wvalid = 0;
    chk("pri_arready_full", 32'(arready), 0);
    chk("pri_size", 32'(size), 0);
    chk("pri_we", 32'(we), 1);
    gnt = 1;
    tick();
    gnt = 0; dvalid = 1;
    tick();
    dvalid = 0; bready = 1;
    chk("pri_bvalid", 32'(bvalid), 1);
    chk("pri_arready_b", 32'(arready), 0);
    tick();
    bready = 0;
    chk("pri_arready_after_b", 32'(arready), 1);
    tick();
    arvalid = 0;
    chk("pri_rd_req", {req, we}, 2'b10);
    chk("pri_rd_addr", 32'(addr), 32'h200);
    gnt = 1;
    tick();
    gnt = 0; dvalid = 1; rdata_i = 32'hCAFE_F00D;
    tick();
    dvalid = 0; rready = 1;
    chk("pri_rdata", rdata_o, 32'hCAFE_F00D);
    chk("pri_rvalid", 32'(rvalid), 1);
    tick();
    rready = 0;
    // bready stall with a new write waiting
    awaddr = 32'h8; wdata = 32'hA5A5; wstrb = 4'h3; awvalid = 1; wvalid = 1;
    tick();
    chk("bp_size", 32'(size), 1);
    awaddr = 32'hC; wdata = 32'h5A; wstrb = 4'h5; gnt = 1;
    tick();
    gnt = 0; dvalid = 1;
    tick();
    dvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_state%0d", i), {bvalid, req, awready}, 3'b100);
      tick();
    end
    bready = 1;
    #1;
    chk("bp_awready_popcycle", 32'(awready), 0);
    tick();
    bready = 0;
    chk("bp_accept_next", {awready, wready, bvalid}, 3'b110);
    tick();
    awvalid = 0; wvalid = 0;
    chk("bp_req2", 32'(req), 1);
    chk("bp_addr2", 32'(addr), 32'hC);
    chk("bp_size_odd", 32'(size), 2);
    gnt = 1;
    tick();
    gnt = 0; dvalid = 1;
    tick();
    dvalid = 0; bready = 1;
    tick();
    bready = 0;
    // AW alone must wait for W
    awaddr = 32'h44; wdata = 32'h77; wstrb = 4'hF; awvalid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("aw_only%0d", i), {awready, wready, req}, 0);
      tick();
    end
    wvalid = 1;
    #1;
    chk("aw_w_join", {awready, wready}, 2'b11);
    tick();
    awvalid = 0; wvalid = 0;
    chk("aw_w_req", 32'(req), 1);
    gnt = 1;
    tick();
    gnt = 0;
    chk("busy_req", 32'(req), 0);
    // reset while busy discards the transaction
    rst_n = 0;
    #1;
    chk("mid_rst_ctrl", {req, bvalid, rvalid, awready, wready, arready}, 0);
    chk("mid_rst_data", {addr, we, size}, 0);
    chk("mid_rst_wdata", wdata_o, 0);
    tick();
    rst_n = 1;
    tick();
    dvalid = 1; rdata_i = 32'hBAD0_BAD0;
    tick();
    dvalid = 0;
    chk("post_rst_no_beat", {bvalid, rvalid, req}, 0);
    tick();
    chk("post_rst_still_idle", {bvalid, rvalid, req}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
